// File: rtl/eeg_drain_pkg.sv
// Shared definitions for the output-RAM drain engine.
//   state_t    : drain FSM states
//   FIFO_DEPTH : depth of the output buffer between RAM read data and out_*
package eeg_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_CW    = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/eeg_oram_drain_if.sv
// Chip output word stream of the drain engine.
//   out_vld : word valid (driven by master)
//   out_rdy : downstream ready (driven by slave)
//   out_dat : output word (driven by master)
interface eeg_oram_drain_if #(
  parameter int unsigned OUT_DW = 8
) ();

  logic              out_vld;
  logic              out_rdy;
  logic [OUT_DW-1:0] out_dat;

  modport master (output out_vld, output out_dat, input out_rdy);
  modport slave  (input out_vld, input out_dat, output out_rdy);

endinterface

// File: rtl/eeg_drain_fifo.sv
// Two-entry buffer with registered head output.
//   clk, rst_n : clock, async active-low reset
//   push, din  : write a word (caller guarantees room)
//   pop        : consume the head word (caller guarantees vld)
//   vld, dout  : head valid / head word, both registered
//   cnt        : current occupancy
module eeg_drain_fifo
  import eeg_drain_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [DW-1:0]      din,
  input  logic               pop,
  output logic               vld,
  output logic [DW-1:0]      dout,
  output logic [FIFO_CW-1:0] cnt
);

  localparam logic [FIFO_CW-1:0] FULL = FIFO_CW'(FIFO_DEPTH);
  localparam logic [FIFO_CW-1:0] ONE  = FIFO_CW'(1);

  logic [DW-1:0] tail;

  // Head lives directly in dout so out_dat never passes through a mux
  // driven by the pop side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      vld  <= 1'b0;
      dout <= '0;
      tail <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == '0) dout <= din;
          else           tail <= din;
          cnt <= cnt + ONE;
          vld <= 1'b1;
        end
        2'b01: begin
          if (cnt == FULL) dout <= tail;
          cnt <= cnt - ONE;
          vld <= (cnt == FULL);
        end
        2'b11: begin
          if (cnt == FULL) begin
            dout <= tail;
            tail <= din;
          end else begin
            dout <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/eeg_oram_drain.sv
// Drains len words from one selected output RAM bank onto the chip output
// stream, buffering returned read data in a 2-entry FIFO.
//   clk, rst_n    : clock, async active-low reset
//   start_i       : single-cycle drain request (accepted only when idle)
//   cfg_oram_idx  : one-hot bank select (lowest set bit wins)
//   cfg_len       : number of words to drain (0 .. 2^ORAM_AW)
//   busy_o        : drain in progress
//   done_o        : single-cycle completion pulse
//   ram_ren_o     : per-bank read enable
//   ram_addr_o    : shared read address
//   ram_rdata_i   : bank read data, valid one cycle after ren
//   out_if        : output word stream (vld/rdy/dat)
module eeg_oram_drain
  import eeg_drain_pkg::*;
#(
  parameter int unsigned ORAM_NUM = 4,
  parameter int unsigned ORAM_AW  = 8,
  parameter int unsigned OUT_DW   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [ORAM_NUM-1:0]        cfg_oram_idx,
  input  logic [ORAM_AW:0]           cfg_len,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [ORAM_NUM-1:0]        ram_ren_o,
  output logic [ORAM_AW-1:0]         ram_addr_o,
  input  logic [ORAM_NUM*OUT_DW-1:0] ram_rdata_i,
  eeg_oram_drain_if.master           out_if
);

  localparam int unsigned LW = ORAM_AW + 1;

  state_t               state;
  logic [ORAM_NUM-1:0]  bank_oh;
  logic [LW-1:0]        len_q;
  logic [LW-1:0]        rd_cnt;
  logic [LW-1:0]        pop_cnt;
  logic                 inflight;
  logic [ORAM_NUM-1:0]  lowest;
  logic                 issue;
  logic                 pop;
  logic [OUT_DW-1:0]    rd_word;
  logic                 fifo_vld;
  logic [OUT_DW-1:0]    fifo_dout;
  logic [FIFO_CW-1:0]   fifo_cnt;

  assign lowest = cfg_oram_idx & (~cfg_oram_idx + ORAM_NUM'(1));
  assign pop    = fifo_vld & out_if.out_rdy;

  // Read issue must see this cycle's pop to sustain one word per cycle,
  // so ren is decoded combinationally from registered state/count plus pop.
  always_comb begin
    issue = 1'b0;
    if (state == READ)
      issue = (fifo_cnt + {1'b0, inflight}) < (pop ? 2'd3 : 2'd2);
  end

  assign ram_ren_o  = issue ? bank_oh : '0;
  assign ram_addr_o = rd_cnt[ORAM_AW-1:0];

  always_comb begin
    rd_word = '0;
    for (int unsigned k = 0; k < ORAM_NUM; k++)
      if (bank_oh[k]) rd_word = rd_word | ram_rdata_i[k*OUT_DW +: OUT_DW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bank_oh  <= '0;
      len_q    <= '0;
      rd_cnt   <= '0;
      pop_cnt  <= '0;
      inflight <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      inflight <= issue;
      done_o   <= 1'b0;
      if (pop) pop_cnt <= pop_cnt + LW'(1);
      unique case (state)
        IDLE: begin
          if (start_i) begin
            bank_oh <= lowest;
            len_q   <= cfg_len;
            rd_cnt  <= '0;
            pop_cnt <= '0;
            busy_o  <= 1'b1;
            if (cfg_len == '0 || cfg_oram_idx == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (issue) begin
            rd_cnt <= rd_cnt + LW'(1);
            if (rd_cnt == len_q - LW'(1)) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (pop && pop_cnt == len_q - LW'(1)) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  eeg_drain_fifo #(
    .DW (OUT_DW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .din   (rd_word),
    .pop   (pop),
    .vld   (fifo_vld),
    .dout  (fifo_dout),
    .cnt   (fifo_cnt)
  );

  assign out_if.out_vld = fifo_vld;
  assign out_if.out_dat = fifo_dout;

endmodule

// File: doc/eeg_oram_drain.md
EEG_ORAM_DRAIN -- requirements
Module: eeg_oram_drain

Interface
REQ-001 Parameter ORAM_NUM, default 4, number of output RAM banks.
REQ-002 Parameter ORAM_AW, default 8, output RAM address width.
REQ-003 Parameter OUT_DW, default 8, output word width (CHIP_OUT_DW).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start_i  input  1  single-cycle drain request.
REQ-007 cfg_oram_idx  input  ORAM_NUM  one-hot bank select, sampled with start_i.
REQ-008 cfg_len  input  ORAM_AW+1  word count to drain, sampled with start_i.
REQ-009 busy_o  output  1  drain in progress.
REQ-010 done_o  output  1  single-cycle completion pulse.
REQ-011 ram_ren_o  output  ORAM_NUM  per-bank read enable.
REQ-012 ram_addr_o  output  ORAM_AW  shared read address.
REQ-013 ram_rdata_i  input  ORAM_NUM*OUT_DW  bank read data, valid 1 cycle after ren; bank k at bits [k*OUT_DW +: OUT_DW].
REQ-014 out_vld  output  1  chip output word valid.
REQ-015 out_rdy  input  1  downstream ready.
REQ-016 out_dat  output  OUT_DW  chip output word.

Function
REQ-017 FSM states IDLE, READ, FLUSH, DONE; reset to IDLE.
REQ-018 start_i SHALL be accepted only in IDLE; ignored in all other states.
REQ-019 On accept: latch bank = lowest set bit of cfg_oram_idx, len = cfg_len; IDLE->READ.
REQ-020 cfg_len==0 or cfg_oram_idx==0: IDLE->DONE, no RAM reads, no out_vld.
REQ-021 READ: issue read at addresses 0,1,...,len-1 in order, one per cycle max, ram_ren_o asserted only on selected bit.
REQ-022 Issue condition: fifo_cnt + inflight - (out_vld & out_rdy) < 2; inflight is 1 if a read was issued previous cycle.
REQ-023 Returned data SHALL be written into a 2-entry FIFO on the cycle after issue; no data is ever dropped.
REQ-024 out_vld = FIFO non-empty; out_dat = FIFO head; both registered, no combinational path from out_rdy to out_vld/out_dat.
REQ-025 out_dat and out_vld SHALL stay stable while out_vld & !out_rdy.
REQ-026 READ->FLUSH after the last read issue; FLUSH->DONE on handshake of word len-1.
REQ-027 DONE lasts one cycle: done_o=1, then IDLE; start_i in DONE is ignored.
REQ-028 busy_o=1 in READ, FLUSH, DONE; 0 in IDLE.
REQ-029 Latency: start_i at cycle T, out_rdy=1 -> ram_ren_o at T+1, first out_vld at T+3.
REQ-030 Throughput: with out_rdy held 1, one word per cycle; len words complete by T+len+2, done_o at T+len+3.
REQ-031 Address counter width ORAM_AW+1; len = 2^ORAM_AW SHALL drain the full bank with ram_addr_o wrapping only after the final read.

Reset
REQ-032 rst_n low SHALL asynchronously force IDLE, FIFO empty, inflight 0, counters 0.
REQ-033 Reset values: busy_o=0, done_o=0, ram_ren_o=0, ram_addr_o=0, out_vld=0, out_dat=0.
REQ-034 Reset mid-drain SHALL abandon the drain; no done_o pulse after release.

Structure
REQ-035 Package eeg_drain_pkg SHALL hold the FSM state enum and FIFO depth constant (2).
REQ-036 Sub-module eeg_drain_fifo (2-entry, registered output, push/pop/cnt) SHALL implement the buffer.

Verification
REQ-037 Bank 2 preloaded 0x10..0x1F, start len=16, out_rdy=1 -> 16 words 0x10..0x1F, first out_vld at T+3, done_o at T+19.
REQ-038 len=8, out_rdy random 50% -> same 8 words in order, out_dat stable under stall, ram_ren_o never while FIFO+inflight full.
REQ-039 len=0 -> done_o at T+1, no ram_ren_o, no out_vld.
REQ-040 cfg_oram_idx=4'b0110, len=4 -> reads only bank 1, addresses 0..3.
REQ-041 len=256 (ORAM_AW=8), out_rdy=1 -> 256 words, addresses 0..255, done_o once.
REQ-042 rst_n low after 5 words of len=16, then new start len=3 -> outputs reset, only 3 new words, single done_o.
